input_skew_buffer: RTL and testbench
====================================

INPUT_SKEW_BUFFER -- requirements
Module: input_skew_buffer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the element width in bits.
REQ-002 The module SHALL have parameter LANES, default 4, giving the number of array rows fed (one lane per row, LANES>=1).
REQ-003 The module SHALL have parameter DEPTH, default 4, giving the elements per lane per block (DEPTH>=1).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the load beat is valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the buffer accepts a load beat.
REQ-008 The module SHALL have port in_data, input, LANES*DATA_W bits: one column; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-009 The module SHALL have port start, input, 1 bit: request to drain a full buffer.
REQ-010 The module SHALL have port skew_rev, input, 1 bit: skew direction, sampled when start is accepted.
REQ-011 The module SHALL have port flush, input, 1 bit: synchronous abort.
REQ-012 The module SHALL have port out_valid, output, LANES bits: per-lane output valid.
REQ-013 The module SHALL have port out_data, output, LANES*DATA_W bits: per-lane skewed element, same lane packing as in_data.
REQ-014 The module SHALL have port busy, output, 1 bit: high in FULL or DRAIN.
REQ-015 The module SHALL have port done, output, 1 bit: one-cycle pulse at drain completion.

Function
REQ-016 The FSM SHALL have exactly the states LOAD, FULL and DRAIN.
REQ-017 In LOAD, in_ready SHALL be 1; a beat (in_valid and in_ready) SHALL store in_data as column k, where k is the load count 0..DEPTH-1, and increment k.
REQ-018 Acceptance of beat DEPTH-1 SHALL move the FSM to FULL on the same edge; in_ready SHALL be 0 in FULL and DRAIN, and in_valid there SHALL be ignored.
REQ-019 start in FULL SHALL move the FSM to DRAIN, latch skew_rev into mode and clear drain counter t to 0; start in LOAD or DRAIN SHALL be ignored.
REQ-020 Lane delay SHALL be d_i = i when mode=0 and d_i = LANES-1-i when mode=1.
REQ-021 In DRAIN cycle t (0..DEPTH+LANES-2), lane i SHALL present out_valid[i]=1 with element (t-d_i) when 0<=t-d_i<DEPTH, and otherwise out_valid[i]=0 with data 0.
REQ-022 out_valid and out_data SHALL be registered, with drain cycle t=0 visible in the first cycle the FSM is in DRAIN; outside DRAIN both SHALL be 0.
REQ-023 After drain cycle DEPTH+LANES-2, the FSM SHALL return to LOAD with k=0; done SHALL be 1 for that one cycle, and in_ready SHALL be 1 in that same cycle.
REQ-024 flush SHALL have priority over all other inputs: the next state SHALL be LOAD with k=0 and t=0, and out_valid, out_data and done SHALL be 0 from the next cycle, with no done pulse.
REQ-025 Stored data SHALL persist until overwritten; clearing on flush SHALL NOT be required.
REQ-026 Counters SHALL be $clog2-sized with no wrap past DEPTH-1 or DEPTH+LANES-2.

Reset
REQ-027 While rst=0, state SHALL be LOAD, k=0, t=0 and mode=0, and in_ready, busy, done, out_valid and out_data SHALL all be 0.
REQ-028 in_ready SHALL be gated to 0 while rst=0 and SHALL go to 1 in the first cycle after rst deasserts.
REQ-029 Reset asserted mid-LOAD or mid-DRAIN SHALL abort immediately, with no done pulse.

Structure
REQ-030 The state encoding and a counter-width function SHALL reside in the shared package skew_pkg.
REQ-031 Per-lane storage and delay selection SHALL be sub-module skew_lane, instantiated LANES times with the lane index as a parameter; the FSM and counters SHALL remain in the top module.

Verification (LANES=4, DEPTH=4, DATA_W=8)
REQ-032 Load lane i, column k = 0x10*i+k; start with skew_rev=0 -> lane0 outputs 00,01,02,03 at t=0..3; lane3 outputs 30..33 at t=3..6; 7 drain cycles; done in the following cycle.
REQ-033 Same data with skew_rev=1 -> lane3 valid at t=0..3 and lane0 at t=3..6; out_valid at t=0 is 4'b1000.
REQ-034 Present 5 beats back-to-back -> in_ready=0 after beat 4; beat 5 is held and accepted in the done cycle as the new column 0.
REQ-035 start during LOAD with k=2 -> ignored; flush at t=3 of a drain -> out_valid=0 next cycle, no done, in_ready=1.
REQ-036 rst low at t=2 -> all outputs 0 asynchronously; after release, a full load/drain completes normally.
REQ-037 LANES=1, DEPTH=1 -> one drain cycle, out_valid=1 with the loaded element, done in the next cycle.

Source files
------------

// File: rtl/skew_pkg.sv
// Shared definitions for the input skew buffer.
//   skew_state_e : controller state encoding (LOAD / FULL / DRAIN)
//   cnt_w()      : bit width of a counter that has to hold the values 0..n-1
package skew_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } skew_state_e;

    // A counter never needs fewer than one bit. This also covers n=1 and n=2.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane (array row) of the input skew buffer: DEPTH-entry column storage
// plus the registered, delay-shifted output for this lane.
//   clk          : clock
//   rst          : asynchronous active-low reset
//   wr_en_i      : store wr_data_i as column wr_col_i
//   wr_col_i     : load column index (0..DEPTH-1)
//   wr_data_i    : element for this lane
//   out_load_i   : register the element for drain cycle calc_t_i
//   out_clr_i    : force the output register to zero (takes priority over load)
//   calc_t_i     : drain cycle whose output is computed now
//   calc_mode_i  : skew direction (0: delay = lane index, 1: reversed)
//   out_valid_o  : registered lane valid
//   out_data_o   : registered lane element (0 when not valid)
module skew_lane
    import skew_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LANES    = 4,
    parameter int DEPTH    = 4,
    parameter int LANE_IDX = 0,
    parameter int K_W      = cnt_w(DEPTH),
    parameter int T_W      = cnt_w(DEPTH + LANES - 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [K_W-1:0]    wr_col_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              out_load_i,
    input  logic              out_clr_i,
    input  logic [T_W-1:0]    calc_t_i,
    input  logic              calc_mode_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    int                delay;
    int                offset;
    logic              hit_d;
    logic [DATA_W-1:0] elem_d;

    // Element index for this lane is (t - delay); it is valid only inside the
    // window 0..DEPTH-1, outside it the lane idles with zero data.
    always_comb begin
        delay  = calc_mode_i ? (LANES - 1 - LANE_IDX) : LANE_IDX;
        offset = int'(calc_t_i) - delay;
        hit_d  = (offset >= 0) && (offset < DEPTH);
        elem_d = '0;
        for (int c = 0; c < DEPTH; c++) begin
            if (hit_d && (offset == c)) begin
                elem_d = mem_q[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < DEPTH; c++) begin
                mem_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < DEPTH; c++) begin
                if (wr_en_i && (int'(wr_col_i) == c)) begin
                    mem_q[c] <= wr_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (out_clr_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (out_load_i) begin
            valid_q <= hit_d;
            data_q  <= elem_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/input_skew_buffer.sv
// Input skew buffer: collects DEPTH columns of LANES elements, then drains
// them with lane i delayed by d_i cycles (d_i = i, or LANES-1-i when reversed)
// so a systolic array sees a diagonal wavefront.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   in_valid  : load beat valid
//   in_ready  : buffer accepts a load beat (LOAD state, out of reset)
//   in_data   : one column, lane i at [i*DATA_W +: DATA_W]
//   start     : drain request, honoured only when full
//   skew_rev  : skew direction, captured with start
//   flush     : synchronous abort back to LOAD
//   out_valid : per-lane valid
//   out_data  : per-lane element, same packing as in_data
//   busy      : FULL or DRAIN
//   done      : one-cycle pulse after the last drain cycle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | accepting columns, k = next column index
// ST_FULL  | all DEPTH columns stored, waiting for start
// ST_DRAIN | presenting drain cycle t = 0..DEPTH+LANES-2 on the outputs
module input_skew_buffer
    import skew_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    start,
    input  logic                    skew_rev,
    input  logic                    flush,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    busy,
    output logic                    done
);

    localparam int K_W = cnt_w(DEPTH);
    localparam int T_W = cnt_w(DEPTH + LANES - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(DEPTH - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(DEPTH + LANES - 2);

    skew_state_e    state_q;
    logic [K_W-1:0] k_q;
    logic [T_W-1:0] t_q;
    logic           mode_q;
    logic           done_q;

    logic           beat;
    logic           wr_en;
    logic           out_load;
    logic           out_clr;
    logic [T_W-1:0] calc_t;
    logic           calc_mode;

    // rst gates in_ready directly so it reads 0 for the whole reset window.
    assign in_ready = (state_q == ST_LOAD) && rst;
    assign beat     = in_valid && in_ready;
    assign busy     = (state_q != ST_LOAD);
    assign done     = done_q;

    // Outputs are registered: the lanes compute the values for the cycle
    // about to be entered (t=0 on the start edge, t+1 while draining).
    always_comb begin
        wr_en     = beat && !flush;
        out_load  = 1'b0;
        out_clr   = 1'b0;
        calc_t    = '0;
        calc_mode = mode_q;
        if (flush) begin
            out_clr = 1'b1;
        end else begin
            case (state_q)
                ST_FULL: begin
                    if (start) begin
                        out_load  = 1'b1;
                        calc_mode = skew_rev;
                    end
                end
                ST_DRAIN: begin
                    if (t_q == T_LAST) begin
                        out_clr = 1'b1;
                    end else begin
                        out_load = 1'b1;
                        calc_t   = t_q + T_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            k_q     <= '0;
            t_q     <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= ST_LOAD;
                k_q     <= '0;
                t_q     <= '0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        if (beat) begin
                            if (k_q == K_LAST) begin
                                state_q <= ST_FULL;
                            end else begin
                                k_q <= k_q + K_W'(1);
                            end
                        end
                    end
                    ST_FULL: begin
                        if (start) begin
                            state_q <= ST_DRAIN;
                            mode_q  <= skew_rev;
                            t_q     <= '0;
                        end
                    end
                    ST_DRAIN: begin
                        if (t_q == T_LAST) begin
                            state_q <= ST_LOAD;
                            k_q     <= '0;
                            t_q     <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            t_q <= t_q + T_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_LOAD;
                        k_q     <= '0;
                        t_q     <= '0;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skew_lane #(
            .DATA_W   (DATA_W),
            .LANES    (LANES),
            .DEPTH    (DEPTH),
            .LANE_IDX (i),
            .K_W      (K_W),
            .T_W      (T_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .wr_en_i     (wr_en),
            .wr_col_i    (k_q),
            .wr_data_i   (in_data[i*DATA_W +: DATA_W]),
            .out_load_i  (out_load),
            .out_clr_i   (out_clr),
            .calc_t_i    (calc_t),
            .calc_mode_i (calc_mode),
            .out_valid_o (out_valid[i]),
            .out_data_o  (out_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_input_skew_buffer.sv
module tb_input_skew_buffer;

    localparam int NL = 4;
    localparam int ND = 4;
    localparam int NT = ND + NL - 1;

    logic          clk;
    logic          rst;
    logic          in_valid, in_ready, start, skew_rev, flush, busy, done;
    logic [31:0]   in_data, out_data;
    logic [3:0]    out_valid;

    logic          in_valid1, in_ready1, start1, skew_rev1, flush1, busy1, done1;
    logic [7:0]    in_data1, out_data1;
    logic [0:0]    out_valid1;

    input_skew_buffer #(.DATA_W(8), .LANES(NL), .DEPTH(ND)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .start(start), .skew_rev(skew_rev), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
    );

    input_skew_buffer #(.DATA_W(8), .LANES(1), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .start(start1), .skew_rev(skew_rev1), .flush(flush1),
        .out_valid(out_valid1), .out_data(out_data1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          rev;
        int          t;
        logic [3:0]  vld;
        logic [31:0] data;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] cols [ND];
    exp_t        sb [$];
    vec_t        vecs [6];
    bit          use_tbl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_std_cols;
        for (int k = 0; k < ND; k++)
            for (int i = 0; i < NL; i++)
                cols[k][i*8 +: 8] = 8'(16 * i + k);
        use_tbl = 1'b1;
    endtask

    // Expected lane outputs for drain cycle t, built from the columns the bench loaded.
    function automatic exp_t model(input int t, input bit rev);
        exp_t e;
        e.vld  = '0;
        e.data = '0;
        for (int i = 0; i < NL; i++) begin
            int d;
            int c;
            d = rev ? (NL - 1 - i) : i;
            c = t - d;
            if (c >= 0 && c < ND) begin
                e.vld[i]         = 1'b1;
                e.data[i*8 +: 8] = cols[c][i*8 +: 8];
            end
        end
        return e;
    endfunction

    task automatic load_cols(input int from, input int upto);
        for (int k = from; k < upto; k++) begin
            chk("ready_before_beat", in_ready, 1);
            in_valid = 1'b1;
            in_data  = cols[k];
            tick;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_drain(input bit rev, input int flush_at);
        exp_t e;
        int   t;
        bit   stop;
        sb.delete();
        for (int i = 0; i < NT; i++) sb.push_back(model(i, rev));
        start    = 1'b1;
        skew_rev = rev;
        tick;
        start    = 1'b0;
        skew_rev = 1'b0;
        t    = 0;
        stop = 1'b0;
        while (sb.size() > 0 && !stop) begin
            e = sb.pop_front();
            chk("drain_valid", {28'd0, out_valid}, {28'd0, e.vld});
            chk("drain_data", out_data, e.data);
            chk("drain_no_done", done, 0);
            chk("drain_not_ready", in_ready, 0);
            for (int j = 0; j < 6; j++) begin
                if (use_tbl && vecs[j].rev == rev && vecs[j].t == t) begin
                    chk("tbl_valid", {28'd0, out_valid}, {28'd0, vecs[j].vld});
                    chk("tbl_data", out_data, vecs[j].data);
                end
            end
            if (t == flush_at) begin
                flush = 1'b1;
                tick;
                flush = 1'b0;
                sb.delete();
                chk("flush_valid", {28'd0, out_valid}, 0);
                chk("flush_data", out_data, 0);
                chk("flush_done", done, 0);
                chk("flush_ready", in_ready, 1);
                chk("flush_busy", busy, 0);
                for (int j = 0; j < 3; j++) begin
                    tick;
                    chk("flush_no_late_done", done, 0);
                end
                stop = 1'b1;
            end else begin
                tick;
                t++;
            end
        end
        if (flush_at < 0) begin
            chk("done_pulse", done, 1);
            chk("done_valid_zero", {28'd0, out_valid}, 0);
            chk("done_data_zero", out_data, 0);
            chk("done_ready", in_ready, 1);
            chk("done_busy", busy, 0);
            tick;
            chk("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{rev: 1'b0, t: 0, vld: 4'b0001, data: 32'h0000_0000};
        vecs[1] = '{rev: 1'b0, t: 3, vld: 4'b1111, data: 32'h3021_1203};
        vecs[2] = '{rev: 1'b0, t: 6, vld: 4'b1000, data: 32'h3300_0000};
        vecs[3] = '{rev: 1'b1, t: 0, vld: 4'b1000, data: 32'h3000_0000};
        vecs[4] = '{rev: 1'b1, t: 3, vld: 4'b1111, data: 32'h3322_1100};
        vecs[5] = '{rev: 1'b1, t: 6, vld: 4'b0001, data: 32'h0000_0003};

        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; start = 1'b0; skew_rev = 1'b0; flush = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; start1 = 1'b0; skew_rev1 = 1'b0; flush1 = 1'b0;
        use_tbl = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", {28'd0, out_valid}, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b1;
        tick;
        chk("post_rst_ready", in_ready, 1);

        // forward skew
        set_std_cols;
        load_cols(0, ND);
        chk("full_busy", busy, 1);
        chk("full_not_ready", in_ready, 0);
        run_drain(1'b0, -1);

        // reverse skew
        load_cols(0, ND);
        run_drain(1'b1, -1);

        // five beats back-to-back: fifth held through drain, taken in done cycle
        for (int b = 0; b < ND; b++) begin
            in_valid = 1'b1;
            in_data  = cols[b];
            tick;
        end
        in_data = 32'hF3F2_F1F0;
        chk("beat5_not_ready", in_ready, 0);
        tick;
        chk("beat5_held_busy", busy, 1);
        run_drain(1'b0, -1);
        in_valid = 1'b0;
        cols[0]  = 32'hF3F2_F1F0;
        use_tbl  = 1'b0;
        load_cols(1, ND);
        chk("beat5_full_busy", busy, 1);
        chk("beat5_full_ready", in_ready, 0);
        run_drain(1'b0, -1);

        // start ignored in LOAD, flush mid-drain
        set_std_cols;
        load_cols(0, 2);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_in_load_busy", busy, 0);
        chk("start_in_load_ready", in_ready, 1);
        load_cols(2, ND);
        chk("after_k2_full", busy, 1);
        run_drain(1'b0, 3);

        // asynchronous reset during drain at t=2
        load_cols(0, ND);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        chk("pre_rst_t2_valid", {28'd0, out_valid}, 32'h7);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", {28'd0, out_valid}, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_done", done, 0);
        rst = 1'b1;
        tick;
        chk("rerelease_ready", in_ready, 1);
        chk("rerelease_busy", busy, 0);
        load_cols(0, ND);
        run_drain(1'b0, -1);

        // LANES=1, DEPTH=1 instance
        chk("d1_ready", in_ready1, 1);
        in_valid1 = 1'b1;
        in_data1  = 8'h5A;
        tick;
        in_valid1 = 1'b0;
        chk("d1_full_busy", busy1, 1);
        chk("d1_full_ready", in_ready1, 0);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        chk("d1_valid", {31'd0, out_valid1}, 1);
        chk("d1_data", {24'd0, out_data1}, 32'h5A);
        chk("d1_no_done", done1, 0);
        tick;
        chk("d1_done", done1, 1);
        chk("d1_valid_off", {31'd0, out_valid1}, 0);
        chk("d1_ready_back", in_ready1, 1);
        tick;
        chk("d1_done_off", done1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
